// File: rtl/dff_error_counter_if.sv
// Stimulus, chain-return and count signals of the DFF error counter; master drives the test, slave is the counter.
interface dff_error_counter_if #(
  parameter int NUM_CHAINS = 10,
  parameter int CNT_W      = 12
);
  logic                        start;
  logic [1:0]                  pattern_mode;
  logic [NUM_CHAINS-1:0]       chain_in_0;
  logic [NUM_CHAINS-1:0]       chain_in_1;
  logic                        pattern_out;
  logic [NUM_CHAINS*CNT_W-1:0] err_cnt_0;
  logic [NUM_CHAINS*CNT_W-1:0] err_cnt_1;
  logic                        save_data;
  logic                        busy;
  logic [15:0]                 window_count;

  modport master (
    output start, pattern_mode, chain_in_0, chain_in_1,
    input  pattern_out, err_cnt_0, err_cnt_1, save_data, busy, window_count
  );

  modport slave (
    input  start, pattern_mode, chain_in_0, chain_in_1,
    output pattern_out, err_cnt_0, err_cnt_1, save_data, busy, window_count
  );
endinterface

// File: rtl/dff_error_counter.sv
// Drives a test pattern into two chips' DFF chains and keeps per-chain saturating mismatch counts per window.
// Counts settle one cycle before save_data rises and stay frozen while it is high; no backpressure, the sink samples on the rise.
module dff_error_counter #(
  parameter int NUM_CHAINS  = 10,
  parameter int CNT_W       = 12,
  parameter int CHAIN_DEPTH = 8,
  parameter int WINDOW      = 1000,
  parameter int SAVE_HOLD   = 4
) (
  input  logic               dff_clk,
  input  logic               reset,
  dff_error_counter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, COUNT, FREEZE, CLEAR} state_t;

  localparam int               STEP_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state, state_nxt;
  logic [STEP_W-1:0]      step, step_nxt;
  logic                   cnt_clr, cnt_en, save_nxt, win_inc, win_clr, phase_clr;
  logic [1:0]             phase;
  logic [CHAIN_DEPTH-1:0] delay_line;
  logic                   expected;
  logic [NUM_CHAINS-1:0]  mismatch_0, mismatch_1;
  logic [CNT_W-1:0]       cnt_0 [NUM_CHAINS];
  logic [CNT_W-1:0]       cnt_1 [NUM_CHAINS];

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    save_nxt  = 1'b0;
    win_inc   = 1'b0;
    win_clr   = 1'b0;
    phase_clr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ARM;
          step_nxt  = '0;
          cnt_clr   = 1'b1;
          win_clr   = 1'b1;
          phase_clr = 1'b1;
        end
      end
      ARM: begin
        if (step == STEP_W'(CHAIN_DEPTH - 1)) begin
          state_nxt = COUNT;
          step_nxt  = '0;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        if (step == STEP_W'(WINDOW - 1)) begin
          state_nxt = FREEZE;
          step_nxt  = '0;
          win_inc   = 1'b1;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      FREEZE: begin
        // First FREEZE cycle keeps save_data low so the sink sees settled counts on the rise.
        if (step == STEP_W'(SAVE_HOLD)) begin
          state_nxt = CLEAR;
          step_nxt  = '0;
        end else begin
          step_nxt = step + STEP_W'(1);
          save_nxt = 1'b1;
        end
      end
      CLEAR: begin
        cnt_clr   = 1'b1;
        state_nxt = COUNT;
        step_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
    if (state != IDLE && !bus.start) begin
      state_nxt = IDLE;
      step_nxt  = '0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      save_nxt  = 1'b0;
      win_inc   = 1'b0;
    end
  end

  always_ff @(posedge dff_clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      step             <= '0;
      bus.save_data    <= 1'b0;
      bus.window_count <= '0;
    end else begin
      state         <= state_nxt;
      step          <= step_nxt;
      bus.save_data <= save_nxt;
      if (win_clr)
        bus.window_count <= '0;
      else if (win_inc)
        bus.window_count <= bus.window_count + 16'd1;
    end
  end

  always_ff @(posedge dff_clk or negedge reset) begin
    if (!reset) begin
      phase           <= '0;
      bus.pattern_out <= 1'b0;
      delay_line      <= '0;
    end else begin
      if (phase_clr)
        phase <= '0;
      else if (state != IDLE)
        phase <= phase + 2'd1;
      case (bus.pattern_mode)
        2'd0:    bus.pattern_out <= 1'b0;
        2'd1:    bus.pattern_out <= 1'b1;
        2'd2:    bus.pattern_out <= phase[0];
        default: bus.pattern_out <= phase[1];
      endcase
      delay_line <= CHAIN_DEPTH'({delay_line, bus.pattern_out});
    end
  end

  assign expected   = delay_line[CHAIN_DEPTH-1];
  assign mismatch_0 = bus.chain_in_0 ^ {NUM_CHAINS{expected}};
  assign mismatch_1 = bus.chain_in_1 ^ {NUM_CHAINS{expected}};

  always_ff @(posedge dff_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        cnt_0[i] <= '0;
        cnt_1[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        cnt_0[i] <= '0;
        cnt_1[i] <= '0;
      end
    end else if (cnt_en) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        if (mismatch_0[i] && cnt_0[i] != CNT_MAX)
          cnt_0[i] <= cnt_0[i] + 1'b1;
        if (mismatch_1[i] && cnt_1[i] != CNT_MAX)
          cnt_1[i] <= cnt_1[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_pack
    assign bus.err_cnt_0[g*CNT_W +: CNT_W] = cnt_0[g];
    assign bus.err_cnt_1[g*CNT_W +: CNT_W] = cnt_1[g];
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_dff_error_counter.sv
// Bench for dff_error_counter: a short-window unit with random errors and a long-window unit for saturation.
module tb_dff_error_counter;
  localparam int NC = 10, CW = 12, D = 8, SH = 4;
  localparam int WA = 100, WB = 5000, PA = WA + SH + 2;
  localparam int CMAX_I = (1 << CW) - 1;
  localparam int DROP_K = D + 1 + 48 * PA + 50;
  localparam logic [NC-1:0] BIT3 = NC'(8);

  typedef struct packed {
    logic [NC*CW-1:0] c0;
    logic [NC*CW-1:0] c1;
    logic [15:0]      wc;
  } exp_t;

  logic dff_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 dff_clk = ~dff_clk;

  dff_error_counter_if #(.NUM_CHAINS(NC), .CNT_W(CW)) bus_a ();
  dff_error_counter_if #(.NUM_CHAINS(NC), .CNT_W(CW)) bus_b ();

  dff_error_counter #(.NUM_CHAINS(NC), .CNT_W(CW), .CHAIN_DEPTH(D), .WINDOW(WA), .SAVE_HOLD(SH))
    dut_a (.dff_clk(dff_clk), .reset(reset), .bus(bus_a));
  dff_error_counter #(.NUM_CHAINS(NC), .CNT_W(CW), .CHAIN_DEPTH(D), .WINDOW(WB), .SAVE_HOLD(SH))
    dut_b (.dff_clk(dff_clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 0;
  bit rst_test = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Ideal chains: each chip's chains return pattern_out D cycles late; injected errors flip bits on top.
  logic [D-1:0]  chain_a = '0;
  logic [D-1:0]  chain_b = '0;
  logic [NC-1:0] inj0, inj1;
  always @(posedge dff_clk) begin
    chain_a <= {chain_a[D-2:0], bus_a.pattern_out};
    chain_b <= {chain_b[D-2:0], bus_b.pattern_out};
  end
  assign bus_a.chain_in_0 = {NC{chain_a[D-1]}} ^ inj0;
  assign bus_a.chain_in_1 = {NC{chain_a[D-1]}} ^ inj1;
  assign bus_b.chain_in_0 = {NC{chain_b[D-1]}};
  assign bus_b.chain_in_1 = {NC{chain_b[D-1]}} & ~(NC'(1) << 9);

  task automatic chk(input string nm, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [NC-1:0] rnd_mask();
    logic [NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i] = ($urandom_range(7) == 0);
    return r;
  endfunction

  // Reference model for unit A: which edges compare, follows from edge count since ARM entry.
  bit a_run = 0;
  int k_a   = 0;
  int a_done = 0;
  int acc0 [NC];
  int acc1 [NC];

  function automatic logic [NC*CW-1:0] pack(input int a [NC]);
    logic [NC*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(a[i]);
    return r;
  endfunction

  task automatic step_a(input bit st, input logic [1:0] md, input logic [NC-1:0] m0, input logic [NC-1:0] m1);
    int m, pos;
    exp_t e;
    @(negedge dff_clk);
    bus_a.start = st;
    bus_a.pattern_mode = md;
    inj0 = m0;
    inj1 = m1;
    if (!a_run) begin
      if (st) begin
        a_run = 1; k_a = 0; a_done = 0;
        for (int i = 0; i < NC; i++) begin acc0[i] = 0; acc1[i] = 0; end
      end
    end else if (!st) begin
      a_run = 0;
    end else begin
      k_a++;
      if (k_a >= D + 1) begin
        m = k_a - (D + 1);
        pos = m % PA;
        if (pos < WA) begin
          if (pos == 0)
            for (int i = 0; i < NC; i++) begin acc0[i] = 0; acc1[i] = 0; end
          for (int i = 0; i < NC; i++) begin
            if (m0[i] && acc0[i] < CMAX_I) acc0[i]++;
            if (m1[i] && acc1[i] < CMAX_I) acc1[i]++;
          end
          if (pos == WA - 1) begin
            a_done++;
            e.c0 = pack(acc0);
            e.c1 = pack(acc1);
            e.wc = 16'(a_done);
            qa.push_back(e);
          end
        end
      end
    end
  endtask

  initial begin : drv_a
    logic [1:0]    md;
    logic [NC-1:0] m0;
    int m, w;
    bus_a.start = 1'b0;
    bus_a.pattern_mode = 2'd2;
    inj0 = '0;
    inj1 = '0;
    #12;
    chk("rst_pattern_out", bus_a.pattern_out, 0);
    chk("rst_save_data", bus_a.save_data, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_window_count", bus_a.window_count, 0);
    chk("rst_err_cnt_0", bus_a.err_cnt_0, 0);
    chk("rst_err_cnt_1", bus_a.err_cnt_1, 0);
    @(negedge dff_clk);
    reset = 1'b1;
    mon_en = 1;
    repeat (4) step_a(0, 2'd2, '0, '0);
    step_a(1, 2'd2, '0, '0);
    md = 2'd2;
    for (int kk = 1; kk < DROP_K; kk++) begin
      m = kk - (D + 1);
      w = (m < 0) ? 0 : m / PA;
      if (w == 0) step_a(1, 2'd2, '0, '0);
      else if (w == 1) step_a(1, 2'd2, BIT3, '0);
      else begin
        if ($urandom_range(31) == 0) md = 2'($urandom_range(3));
        m0 = rnd_mask();
        if (w == 48) m0 = m0 | BIT3;
        step_a(1, md, m0, rnd_mask());
      end
    end
    step_a(0, md, rnd_mask() | BIT3, rnd_mask());
    repeat (4) step_a(0, md, '0, '0);
    chk("stop_chain3_is_50", 32'(acc0[3]), 50);
    chk("stop_hold_err_cnt_0", bus_a.err_cnt_0, pack(acc0));
    chk("stop_hold_err_cnt_1", bus_a.err_cnt_1, pack(acc1));
    chk("stop_window_count", bus_a.window_count, 16'(a_done));
    chk("stop_busy", bus_a.busy, 0);
    chk("stop_save_data", bus_a.save_data, 0);
    step_a(1, 2'd1, rnd_mask(), rnd_mask());
    step_a(1, 2'd1, rnd_mask(), rnd_mask());
    chk("arm_err_cnt_0", bus_a.err_cnt_0, 0);
    chk("arm_err_cnt_1", bus_a.err_cnt_1, 0);
    chk("arm_window_count", bus_a.window_count, 0);
    chk("arm_busy", bus_a.busy, 1);
    for (int kk = 2; kk <= D + 1 + WA + 1; kk++) step_a(1, 2'd1, rnd_mask(), rnd_mask());
    @(negedge dff_clk);
    chk("pre_rst_save_data", bus_a.save_data, 1);
    chk("pre_rst_pattern_out", bus_a.pattern_out, 1);
    rst_test = 1;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_save_data", bus_a.save_data, 0);
    chk("async_rst_err_cnt_0", bus_a.err_cnt_0, 0);
    chk("async_rst_err_cnt_1", bus_a.err_cnt_1, 0);
    chk("async_rst_pattern_out", bus_a.pattern_out, 0);
    chk("async_rst_busy", bus_a.busy, 0);
    chk("async_rst_window_count", bus_a.window_count, 0);
    #20 reset = 1'b1;
    chk("a_windows_all_saved", 32'(qa.size()), 0);
    chk("b_windows_all_saved", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : drv_b
    exp_t e;
    bus_b.start = 1'b0;
    bus_b.pattern_mode = 2'd1;
    wait (mon_en);
    e.c0 = '0;
    e.c1 = '0;
    e.c1[9*CW +: CW] = CW'((WB > CMAX_I) ? CMAX_I : WB);
    e.wc = 16'd1;
    qb.push_back(e);
    @(negedge dff_clk);
    bus_b.start = 1'b1;
    repeat (D + WB + SH + 8) @(negedge dff_clk);
    bus_b.start = 1'b0;
  end

  initial begin : mon_a
    logic prev_save, po_h1, po_h2, po;
    logic [1:0] last_mode;
    int hold, mode_run, busy_run;
    bit zero_pend;
    exp_t e;
    logic [NC*CW-1:0] prev_c0, prev_c1;
    prev_save = 0; po_h1 = 0; po_h2 = 0; last_mode = 0;
    hold = 0; mode_run = 0; busy_run = 0; zero_pend = 0;
    prev_c0 = '0; prev_c1 = '0;
    forever begin
      @(posedge dff_clk);
      #1;
      if (!mon_en || rst_test) begin
        prev_save = 0; hold = 0; zero_pend = 0; busy_run = 0; mode_run = 0;
      end else begin
        po = bus_a.pattern_out;
        if (bus_a.pattern_mode == last_mode) mode_run++;
        else mode_run = 1;
        last_mode = bus_a.pattern_mode;
        if (mode_run >= 3 && busy_run >= 3) begin
          case (last_mode)
            2'd0: chk("pattern_all0", po, 0);
            2'd1: chk("pattern_all1", po, 1);
            2'd2: chk("pattern_alternating", po, !po_h1);
            default: chk("pattern_pairs", po, !po_h2);
          endcase
        end
        busy_run = bus_a.busy ? busy_run + 1 : 0;
        po_h2 = po_h1;
        po_h1 = po;
        if (bus_a.save_data && !prev_save) begin
          if (qa.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL a_unexpected_save: save_data rose with no completed window");
          end else begin
            e = qa.pop_front();
            chk("a_err_cnt_0_at_save", bus_a.err_cnt_0, e.c0);
            chk("a_err_cnt_1_at_save", bus_a.err_cnt_1, e.c1);
            chk("a_err_cnt_0_before_save", prev_c0, e.c0);
            chk("a_err_cnt_1_before_save", prev_c1, e.c1);
            chk("a_window_count", bus_a.window_count, e.wc);
          end
        end
        if (bus_a.save_data) hold++;
        if (!bus_a.save_data && prev_save) begin
          chk("a_save_hold_cycles", 32'(hold), SH);
          hold = 0;
          zero_pend = 1;
        end else if (zero_pend) begin
          zero_pend = 0;
          if (bus_a.busy) begin
            chk("a_err_cnt_0_cleared", bus_a.err_cnt_0, 0);
            chk("a_err_cnt_1_cleared", bus_a.err_cnt_1, 0);
          end
        end
        prev_save = bus_a.save_data;
        prev_c0 = bus_a.err_cnt_0;
        prev_c1 = bus_a.err_cnt_1;
      end
    end
  end

  initial begin : mon_b
    logic prev_save;
    exp_t e;
    prev_save = 0;
    forever begin
      @(posedge dff_clk);
      #1;
      if (mon_en && !rst_test) begin
        if (bus_b.save_data && !prev_save) begin
          if (qb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL b_unexpected_save: save_data rose with no completed window");
          end else begin
            e = qb.pop_front();
            chk("b_err_cnt_0_at_save", bus_b.err_cnt_0, e.c0);
            chk("b_err_cnt_1_saturated", bus_b.err_cnt_1, e.c1);
            chk("b_window_count", bus_b.window_count, e.wc);
          end
        end
        prev_save = bus_b.save_data;
      end
    end
  end
endmodule
